// File: rtl/run_det_pkg.sv
// Shared width helpers and mode constants for the run-length detector.
package run_det_pkg;
    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int run_w(input int run_len);
        return (clog2(run_len) < 1) ? 1 : clog2(run_len);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/mealy_run_detector.sv
// Mealy detector flagging the bit that completes RUN_LEN consecutive
// TARGET samples, with run-time overlap select and a saturating hit count.
module mealy_run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 8,
    localparam int RUN_W  = run_w(RUN_LEN)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             IN,
    input  logic             TARGET,
    input  logic             OVERLAP,
    input  logic             CLEAR,
    output logic             OUT,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [RUN_W-1:0] RUN
);
    localparam logic [RUN_W-1:0] LAST = RUN_W'(RUN_LEN - 1);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             tgt_q;
    logic             tgt_d;
    logic             match;
    logic [RUN_W-1:0] eff_run;

    assign match   = EN & (IN == TARGET);
    // A changed target starts a fresh run rather than extending the old one.
    assign eff_run = (TARGET == tgt_q) ? run_q : '0;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            run_q <= '0;
            tgt_q <= 1'b0;
        end else begin
            run_q <= run_d;
            tgt_q <= tgt_d;
        end
    end

    always_comb begin
        run_d = run_q;
        tgt_d = tgt_q;
        if (CLEAR) begin
            run_d = '0;
            tgt_d = TARGET;
        end else if (EN) begin
            tgt_d = TARGET;
            if (OUT) begin
                run_d = (OVERLAP == MODE_OVL) ? LAST : '0;
            end else if (match) begin
                run_d = eff_run + 1'b1;
            end else begin
                run_d = '0;
            end
        end
    end

    always_comb begin
        OUT = match & (eff_run == LAST) & ~CLEAR & RESET;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_hits (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .clr  (CLEAR),
        .inc  (OUT),
        .q    (HIT_CNT)
    );

    assign RUN = run_q;
endmodule

// File: tb/tb_mealy_run_detector.sv
// Scoreboard bench: three detector instances share one stimulus stream
// and are compared against a segment-length reference model.
module tb_mealy_run_detector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic din = 1'b0;
    logic tgt = 1'b0;
    logic ovl = 1'b0;
    logic clr = 1'b0;

    logic       out6, out3, out1;
    logic [7:0] cnt6, cnt3;
    logic [1:0] cnt1;
    logic [2:0] run6;
    logic [1:0] run3;
    logic [0:0] run1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]      out;
        logic [2:0][7:0] cnt;
        logic [2:0][7:0] run;
    } exp_t;

    exp_t sb[$];

    int lens[3] = '{6, 3, 1};
    int cmax[3] = '{255, 255, 3};
    int seg[3];
    int mtgt[3];
    int mcnt[3];

    always #5 clk = ~clk;

    mealy_run_detector #(.RUN_LEN(6), .CNT_W(8)) u6 (
        .CLOCK(clk), .RESET(rst_n), .EN(en), .IN(din),
        .TARGET(tgt), .OVERLAP(ovl), .CLEAR(clr),
        .OUT(out6), .HIT_CNT(cnt6), .RUN(run6)
    );

    mealy_run_detector #(.RUN_LEN(3), .CNT_W(8)) u3 (
        .CLOCK(clk), .RESET(rst_n), .EN(en), .IN(din),
        .TARGET(tgt), .OVERLAP(ovl), .CLEAR(clr),
        .OUT(out3), .HIT_CNT(cnt3), .RUN(run3)
    );

    mealy_run_detector #(.RUN_LEN(1), .CNT_W(2)) u1 (
        .CLOCK(clk), .RESET(rst_n), .EN(en), .IN(din),
        .TARGET(tgt), .OVERLAP(ovl), .CLEAR(clr),
        .OUT(out1), .HIT_CNT(cnt1), .RUN(run1)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    // seg = length of the current unbroken matching segment, uncapped.
    task automatic step(input logic r, input logic e, input logic i,
                        input logic t, input logic o, input logic c);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        en    = e;
        din   = i;
        tgt   = t;
        ovl   = o;
        clr   = c;
        x = '0;
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                seg[k]  = 0;
                mtgt[k] = 0;
                mcnt[k] = 0;
            end else if (c) begin
                seg[k]  = 0;
                mcnt[k] = 0;
                mtgt[k] = int'(t);
            end else if (e) begin
                if (int'(t) != mtgt[k]) seg[k] = 0;
                mtgt[k] = int'(t);
                if (i == t) begin
                    if (seg[k] + 1 >= lens[k]) begin
                        x.out[k] = 1'b1;
                        if (mcnt[k] < cmax[k]) mcnt[k]++;
                        seg[k] = o ? seg[k] + 1 : 0;
                    end else begin
                        seg[k]++;
                    end
                end else begin
                    seg[k] = 0;
                end
            end
            x.cnt[k] = 8'(mcnt[k]);
            x.run[k] = 8'((seg[k] < lens[k]) ? seg[k] : lens[k] - 1);
        end
        sb.push_back(x);
    endtask

    initial begin : monitor
        logic [2:0] o_s;
        int c_s[3];
        int r_s[3];
        exp_t ex;
        forever begin
            @(negedge clk);
            #2;
            o_s = {out1, out3, out6};
            @(posedge clk);
            #1;
            c_s[0] = int'(cnt6);
            c_s[1] = int'(cnt3);
            c_s[2] = int'(cnt1);
            r_s[0] = int'(run6);
            r_s[1] = int'(run3);
            r_s[2] = int'(run1);
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("out_L%0d", lens[k]),
                          int'(o_s[k]), int'(ex.out[k]));
                    check($sformatf("hitcnt_L%0d", lens[k]),
                          c_s[k], int'(ex.cnt[k]));
                    check($sformatf("run_L%0d", lens[k]),
                          r_s[k], int'(ex.run[k]));
                end
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic t, input logic o);
        logic [15:0] s;
        s = 16'b0001110000000111;
        step(1'b1, 1'b0, 1'b0, t, o, 1'b1);
        for (int b = 0; b < 16; b++) begin
            step(1'b1, 1'b1, s[b], t, o, 1'b0);
        end
        after_edge();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic t_cur;
        logic o_cur;
        logic r;
        logic e;
        logic i;
        logic c;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_out6", int'(out6), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("reset_cnt6", int'(cnt6), 0);
        check("reset_run6", int'(run6), 0);

        stream(1'b0, 1'b0);
        check("t1_cnt6", int'(cnt6), 1);
        check("t1_run6", int'(run6), 3);

        stream(1'b0, 1'b1);
        check("t2_cnt6", int'(cnt6), 2);

        stream(1'b1, 1'b0);
        check("t3_cnt3", int'(cnt3), 2);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("t4_gap_out6", int'(out6), 1);
        for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("t4_tgtchg_out6", int'(out6), 0);
        after_edge();
        check("t4_cnt6", int'(cnt6), 1);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("t5_rst_out6", int'(out6), 0);
        for (int n = 0; n < 2; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
        check("t5_cnt6", int'(cnt6), 0);
        check("t5_run6", int'(run6), 2);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        check("t5_clr_out6", int'(out6), 0);
        after_edge();
        check("t5_clr_cnt6", int'(cnt6), 0);

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            #2;
            check("t6_out1", int'(out1), 1);
        end
        after_edge();
        check("t6_cnt1", int'(cnt1), 3);

        t_cur = 1'b0;
        o_cur = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) t_cur = ~t_cur;
            if ($urandom_range(0, 19) == 0) o_cur = ~o_cur;
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 4) != 0);
            i = ($urandom_range(0, 6) == 0) ? ~t_cur : t_cur;
            c = ($urandom_range(0, 149) == 0);
            step(r, e, i, t_cur, o_cur, c);
        end

        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
